fetch_pc_ctrl: RTL and testbench
================================

Name: fetch_pc_ctrl

Overview:
Fetch-stage next-PC controller that sits directly downstream of the BTB. It owns the fetch PC register and drives current_pc into the BTB. It combines the BTB's target_pc/valid_target with its own table of 2-bit saturating direction counters (PHT) to choose the next PC. It redirects on execute-stage mispredicts and trains the PHT from resolved branches.

Parameters:
PHT_ROWS, 16, number of 2-bit counters; must be a power of two.
PHT_IDX, $clog2(PHT_ROWS), index width; index = pc[PHT_IDX+1:2].
RESET_PC, 32'h0, fetch PC loaded on reset.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high.
enable  in  1  global enable; when low, all state holds (reset still applies).
if_stall  in  1  downstream not ready; PC holds.
if_branch  in  1  predecode: instruction at current_pc is a conditional branch.
target_pc  in  32  BTB predicted target for current_pc.
valid_target  in  1  BTB hit for current_pc.
ex_en_branch  in  1  a branch resolved this cycle.
ex_pc  in  32  PC of the resolved branch.
ex_branch_taken  in  1  resolved direction.
ex_mispredict  in  1  resolved branch was mispredicted; flush and redirect.
ex_redirect_pc  in  32  correct PC after mispredict.
current_pc  out  32  fetch PC; also drives the BTB lookup.
next_pc  out  32  PC that will be loaded on the next advancing edge.
pred_taken  out  1  prediction attached to the instruction at current_pc.
if_valid  out  1  instruction at current_pc is valid to pass downstream.
mispredict_count  out  32  debug: saturating count of ex_mispredict pulses.

Behaviour:
- Reset: current_pc=RESET_PC, state=IDLE, all PHT entries=2'b01 (weakly not-taken), mispredict_count=0. Combinational outputs evaluate from these values: if_valid=0, pred_taken=0, next_pc=RESET_PC.
- The prediction is combinational in the same cycle: pred_taken = if_branch & valid_target & pht[current_pc idx][1].
- next_pc priority: (1) ex_mispredict -> ex_redirect_pc; (2) state!=RUN or if_stall -> current_pc; (3) pred_taken -> target_pc; (4) otherwise current_pc+4, 32-bit wrap (32'hFFFFFFFC -> 32'h0).
- current_pc <= next_pc on every rising edge with enable=1. ex_mispredict overrides if_stall.
- FSM:
  - IDLE: if_valid=0. Goes to RUN on the first cycle with enable=1.
  - RUN: if_valid = ~if_stall & ~ex_mispredict. Goes to REDIRECT on ex_mispredict.
  - REDIRECT: one bubble cycle; if_valid=0; PC holds at the redirect PC. Goes to RUN next cycle. A further ex_mispredict in this state reloads the PC and stays in REDIRECT.
  - reset in any state returns to IDLE.
- PHT update on ex_en_branch & enable, at index ex_pc[PHT_IDX+1:2]: taken -> saturating increment (max 2'b11); not taken -> saturating decrement (min 2'b00).
- The update is written on the clock edge. A same-cycle lookup of the same index sees the old value; there is no bypass.
- ex_mispredict without ex_en_branch still redirects; the PHT is not touched.
- mispredict_count increments on each enabled ex_mispredict and saturates at 32'hFFFFFFFF.
- With enable=0: no PC, FSM, PHT, or counter updates. if_valid=0.

Decomposition:
- Shared package (bp_pkg): PHT_ROWS/PHT_IDX defaults; typedef for the 2-bit counter; enum constants for the counter states (SNT=00, WNT=01, WT=10, ST=11); FSM state enum (IDLE, RUN, REDIRECT).
- One sub-module: pht_2bit, the counter array with read port (current_pc index) and update port (ex_pc index, taken).
- PC register, FSM, and mux logic stay in fetch_pc_ctrl.

Test Plan:
- Reset, then enable=1 with no branches -> IDLE for one cycle with if_valid=0; then current_pc sequences 0, 4, 8, C with if_valid=1 and pred_taken=0.
- Hold current_pc=32'h10 with if_branch=1, valid_target=1, target_pc=32'h40, PHT[4]=01 -> pred_taken=0 and next_pc=32'h14. Train ex_pc=32'h10 taken twice (PHT[4]=11), revisit 32'h10 -> pred_taken=1 and next_pc=32'h40.
- Saturation: four taken updates on ex_pc=32'h8 keep PHT[2]=11; four not-taken updates bring it to 00 with no further change.
- Mispredict with if_stall=1 at current_pc=32'h20, ex_redirect_pc=32'h100 -> next cycle current_pc=32'h100 with if_valid=0 (REDIRECT); the following cycle if_valid=1 and mispredict_count=1.
- Same-cycle update and lookup on index 3 (current_pc=32'hC, ex_pc=32'h4C, counter 01, taken) -> pred_taken uses 01 (0); the next lookup sees 10 (1).
- Assert reset while in REDIRECT -> next edge current_pc=RESET_PC, IDLE, all PHT entries=01, mispredict_count=0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types for the fetch-stage branch predictor: counter encodings and fetch FSM states.
package bp_pkg;

  localparam int unsigned PHT_ROWS_DEF = 16;
  localparam int unsigned PHT_IDX_DEF  = $clog2(PHT_ROWS_DEF);

  typedef logic [1:0] ctr_t;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StRedirect
  } state_e;

  function automatic ctr_t ctr_train(input ctr_t cur, input logic taken);
    ctr_t res;
    res = cur;
    if (taken && cur != ctr_t'(ST)) res = cur + 2'd1;
    if (!taken && cur != ctr_t'(SNT)) res = cur - 2'd1;
    return res;
  endfunction

endpackage

// File: rtl/pht_2bit.sv
// Table of 2-bit saturating direction counters; one async read port, one clocked update port.
module pht_2bit
  import bp_pkg::*;
#(
  parameter int unsigned PHT_ROWS = PHT_ROWS_DEF,
  parameter int unsigned PHT_IDX  = $clog2(PHT_ROWS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [PHT_IDX-1:0] rd_idx,
  output ctr_t               rd_ctr,
  input  logic               upd_en,
  input  logic [PHT_IDX-1:0] upd_idx,
  input  logic               upd_taken
);

  ctr_t ctr_q [PHT_ROWS];
  ctr_t ctr_d [PHT_ROWS];

  // Read returns the pre-update value; no write-to-read bypass.
  assign rd_ctr = ctr_q[rd_idx];

  always_comb begin
    for (int i = 0; i < int'(PHT_ROWS); i++) ctr_d[i] = ctr_q[i];
    if (upd_en) ctr_d[upd_idx] = ctr_train(ctr_q[upd_idx], upd_taken);
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < int'(PHT_ROWS); i++) begin
      if (reset) ctr_q[i] <= ctr_t'(WNT);
      else       ctr_q[i] <= ctr_d[i];
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC register, next-PC selection, redirect FSM and direction prediction using the BTB
// result combined with a local 2-bit counter table.
module fetch_pc_ctrl
  import bp_pkg::*;
#(
  parameter int unsigned PHT_ROWS = PHT_ROWS_DEF,
  parameter int unsigned PHT_IDX  = $clog2(PHT_ROWS),
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        if_stall,
  input  logic        if_branch,
  input  logic [31:0] target_pc,
  input  logic        valid_target,
  input  logic        ex_en_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_branch_taken,
  input  logic        ex_mispredict,
  input  logic [31:0] ex_redirect_pc,
  output logic [31:0] current_pc,
  output logic [31:0] next_pc,
  output logic        pred_taken,
  output logic        if_valid,
  output logic [31:0] mispredict_count
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  ctr_t        rd_ctr;

  pht_2bit #(
    .PHT_ROWS(PHT_ROWS),
    .PHT_IDX (PHT_IDX)
  ) u_pht (
    .clock    (clock),
    .reset    (reset),
    .rd_idx   (pc_q[PHT_IDX+1:2]),
    .rd_ctr   (rd_ctr),
    .upd_en   (ex_en_branch & enable),
    .upd_idx  (ex_pc[PHT_IDX+1:2]),
    .upd_taken(ex_branch_taken)
  );

  assign current_pc       = pc_q;
  assign mispredict_count = cnt_q;
  assign pred_taken       = if_branch & valid_target & rd_ctr[1];

  always_comb begin
    if (ex_mispredict)                          next_pc = ex_redirect_pc;
    else if (state_q != StRun || if_stall)      next_pc = pc_q;
    else if (pred_taken)                        next_pc = target_pc;
    else                                        next_pc = pc_q + 32'd4;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    if_valid = 1'b0;
    if (enable) begin
      pc_d = next_pc;
      if (ex_mispredict && cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
      unique case (state_q)
        StIdle: state_d = StRun;
        StRun: begin
          if_valid = ~if_stall & ~ex_mispredict;
          if (ex_mispredict) state_d = StRedirect;
        end
        StRedirect: state_d = ex_mispredict ? StRedirect : StRun;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: sequencing, prediction, counter saturation, redirect and reset.
module tb_fetch_pc_ctrl;

  logic        clock = 1'b0;
  logic        reset, enable, if_stall, if_branch, valid_target;
  logic [31:0] target_pc, ex_pc, ex_redirect_pc;
  logic        ex_en_branch, ex_branch_taken, ex_mispredict;
  logic [31:0] current_pc, next_pc, mispredict_count;
  logic        pred_taken, if_valid;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  fetch_pc_ctrl dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .if_stall        (if_stall),
    .if_branch       (if_branch),
    .target_pc       (target_pc),
    .valid_target    (valid_target),
    .ex_en_branch    (ex_en_branch),
    .ex_pc           (ex_pc),
    .ex_branch_taken (ex_branch_taken),
    .ex_mispredict   (ex_mispredict),
    .ex_redirect_pc  (ex_redirect_pc),
    .current_pc      (current_pc),
    .next_pc         (next_pc),
    .pred_taken      (pred_taken),
    .if_valid        (if_valid),
    .mispredict_count(mispredict_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1; enable = 0; if_stall = 0; if_branch = 0; valid_target = 0;
    target_pc = 0; ex_pc = 0; ex_redirect_pc = 0;
    ex_en_branch = 0; ex_branch_taken = 0; ex_mispredict = 0;
    step();
    chk("rst_pc", current_pc, 32'h0);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_pred", {31'b0, pred_taken}, 32'd0);
    chk("rst_next", next_pc, 32'h0);
    chk("rst_cnt", mispredict_count, 32'd0);

    // Sequential fetch
    reset = 0; enable = 1; settle();
    chk("idle_valid", {31'b0, if_valid}, 32'd0);
    chk("idle_next", next_pc, 32'h0);
    step();
    chk("seq_pc0", current_pc, 32'h0);
    chk("seq_valid0", {31'b0, if_valid}, 32'd1);
    chk("seq_next0", next_pc, 32'h4);
    step(); chk("seq_pc4", current_pc, 32'h4);
    step(); chk("seq_pc8", current_pc, 32'h8);
    step(); chk("seq_pcc", current_pc, 32'hC);
    chk("seq_pred", {31'b0, pred_taken}, 32'd0);
    step(); chk("seq_pc10", current_pc, 32'h10);

    // Prediction at 0x10 with weakly not-taken counter, then train
    if_stall = 1; if_branch = 1; valid_target = 1; target_pc = 32'h40; settle();
    chk("wnt_pred", {31'b0, pred_taken}, 32'd0);
    chk("stall_next", next_pc, 32'h10);
    chk("stall_valid", {31'b0, if_valid}, 32'd0);
    if_stall = 0; settle();
    chk("wnt_next", next_pc, 32'h14);
    if_stall = 1; ex_en_branch = 1; ex_pc = 32'h10; ex_branch_taken = 1;
    step(); step();
    ex_en_branch = 0; settle();
    chk("st_pred", {31'b0, pred_taken}, 32'd1);
    if_stall = 0; settle();
    chk("st_next", next_pc, 32'h40);
    step(); chk("taken_pc", current_pc, 32'h40);
    if_branch = 0;
    step(); step(); chk("pc48", current_pc, 32'h48);

    // Saturation of entry 2 (observed through pc 0x48)
    if_stall = 1; if_branch = 1; target_pc = 32'h20;
    ex_en_branch = 1; ex_pc = 32'h8; ex_branch_taken = 1;
    repeat (4) step();
    ex_en_branch = 0; settle();
    chk("sat_hi", {31'b0, pred_taken}, 32'd1);
    ex_en_branch = 1; ex_branch_taken = 0; step();
    ex_en_branch = 0; settle();
    chk("sat_hi_dec1", {31'b0, pred_taken}, 32'd1);
    ex_en_branch = 1; repeat (3) step();
    ex_en_branch = 0; settle();
    chk("sat_lo", {31'b0, pred_taken}, 32'd0);
    ex_en_branch = 1; repeat (2) step();
    ex_branch_taken = 1; step();
    ex_en_branch = 0; settle();
    chk("sat_lo_inc1", {31'b0, pred_taken}, 32'd0);
    ex_en_branch = 1; step();
    ex_en_branch = 0; settle();
    chk("sat_lo_inc2", {31'b0, pred_taken}, 32'd1);
    if_stall = 0; settle();
    chk("pred_next20", next_pc, 32'h20);
    step(); chk("pc20", current_pc, 32'h20);

    // Mispredict while stalled
    if_branch = 0; if_stall = 1; ex_mispredict = 1; ex_redirect_pc = 32'h100; settle();
    chk("mp_next", next_pc, 32'h100);
    chk("mp_valid", {31'b0, if_valid}, 32'd0);
    step();
    ex_mispredict = 0; if_stall = 0; settle();
    chk("redir_pc", current_pc, 32'h100);
    chk("redir_valid", {31'b0, if_valid}, 32'd0);
    chk("redir_next", next_pc, 32'h100);
    chk("redir_cnt", mispredict_count, 32'd1);
    step();
    chk("post_redir_pc", current_pc, 32'h100);
    chk("post_redir_valid", {31'b0, if_valid}, 32'd1);
    chk("post_redir_cnt", mispredict_count, 32'd1);
    chk("post_redir_next", next_pc, 32'h104);

    // Same-cycle update and lookup on index 3
    ex_mispredict = 1; ex_redirect_pc = 32'hC; step();
    ex_mispredict = 0;
    chk("pcc_redir", current_pc, 32'hC);
    step(); chk("pcc_run", current_pc, 32'hC);
    if_stall = 1; if_branch = 1; valid_target = 1; target_pc = 32'h80;
    ex_en_branch = 1; ex_pc = 32'h4C; ex_branch_taken = 1; settle();
    chk("bypass_old", {31'b0, pred_taken}, 32'd0);
    step();
    ex_en_branch = 0; settle();
    chk("bypass_new", {31'b0, pred_taken}, 32'd1);
    chk("cnt2", mispredict_count, 32'd2);

    // Enable low freezes everything
    enable = 0; ex_mispredict = 1; ex_redirect_pc = 32'h300; if_stall = 0; settle();
    chk("dis_valid", {31'b0, if_valid}, 32'd0);
    step();
    chk("dis_pc", current_pc, 32'hC);
    chk("dis_cnt", mispredict_count, 32'd2);

    // PC wrap
    enable = 1; ex_redirect_pc = 32'hFFFF_FFF8; step();
    ex_mispredict = 0; if_branch = 0;
    chk("wrap_redir", current_pc, 32'hFFFF_FFF8);
    chk("cnt3", mispredict_count, 32'd3);
    step(); step();
    chk("wrap_pcfc", current_pc, 32'hFFFF_FFFC);
    chk("wrap_next", next_pc, 32'h0);

    // Back-to-back mispredicts stay in REDIRECT
    ex_mispredict = 1; ex_redirect_pc = 32'h300; step();
    chk("mp300", current_pc, 32'h300);
    ex_redirect_pc = 32'h304; step();
    chk("mp304", current_pc, 32'h304);
    chk("cnt5", mispredict_count, 32'd5);
    ex_mispredict = 0; settle();
    chk("mp2_valid", {31'b0, if_valid}, 32'd0);
    chk("mp2_next", next_pc, 32'h304);

    // Reset from REDIRECT
    reset = 1; step();
    reset = 0; settle();
    chk("rr_pc", current_pc, 32'h0);
    chk("rr_cnt", mispredict_count, 32'd0);
    chk("rr_valid", {31'b0, if_valid}, 32'd0);
    chk("rr_next", next_pc, 32'h0);
    if_branch = 1; valid_target = 1; target_pc = 32'h80;
    step(); chk("rr_run_pc", current_pc, 32'h0);
    step(); step();
    chk("rr_pc8", current_pc, 32'h8);
    chk("rr_pht2", {31'b0, pred_taken}, 32'd0);
    step(); chk("rr_pht3", {31'b0, pred_taken}, 32'd0);
    step();
    chk("rr_pc10", current_pc, 32'h10);
    chk("rr_pht4", {31'b0, pred_taken}, 32'd0);
    if_stall = 1; ex_en_branch = 1; ex_pc = 32'h10; ex_branch_taken = 1; step();
    ex_en_branch = 0; settle();
    chk("rr_pht4_wnt", {31'b0, pred_taken}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
